// File: rtl/ulaplus_ports.sv
// ULAplus register/data port block: palette write posting buffer, mode enable and readback.
// Optional shadow palette readback is enabled by defining ULAPLUS_READBACK_EN.
module ulaplus_ports (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       port_wr,
    input  logic       port_rd,
    input  logic       port_sel,
    input  logic [7:0] din,
    output logic [7:0] dout,
    input  logic       atm_palwr,
    output logic       up_ena,
    output logic       up_palwr,
    output logic [5:0] up_paladdr,
    output logic [7:0] up_paldata
);

    typedef enum logic [0:0] {
        BUF_IDLE = 1'b0,
        BUF_PEND = 1'b1
    } buf_state_e;

    buf_state_e state_q;
    logic [7:0] reg_sel_q;
    logic       up_ena_q;
    logic       up_palwr_q;
    logic [5:0] up_paladdr_q;
    logic [7:0] up_paldata_q;
    logic [7:0] dout_q;
    logic [5:0] pend_addr_q;
    logic [7:0] pend_data_q;

    logic [1:0] group_s;
    logic [5:0] index_s;
    logic       rd_s;
    logic       pal_wr_s;
    logic       ena_wr_s;
    logic       cand_valid_s;
    logic [5:0] cand_addr_s;
    logic [7:0] cand_data_s;
    logic       issue_s;
    logic [7:0] pal_rd_s;
    logic [7:0] rd_data_s;

`ifdef ULAPLUS_READBACK_EN
    logic [7:0] shadow_q [64];
`endif

    // Decode strobes and select the entry that may be issued this clock
    always_comb begin
        group_s  = reg_sel_q[7:6];
        index_s  = reg_sel_q[5:0];
        rd_s     = port_rd & ~port_wr;
        pal_wr_s = port_wr & port_sel & (group_s == 2'b00);
        ena_wr_s = port_wr & port_sel & (group_s == 2'b01);
        // A fresh data write supersedes any entry still pending (last write wins)
        if (pal_wr_s) begin
            cand_valid_s = 1'b1;
            cand_addr_s  = index_s;
            cand_data_s  = din;
        end else if (state_q == BUF_PEND) begin
            cand_valid_s = 1'b1;
            cand_addr_s  = pend_addr_q;
            cand_data_s  = pend_data_q;
        end else begin
            cand_valid_s = 1'b0;
            cand_addr_s  = pend_addr_q;
            cand_data_s  = pend_data_q;
        end
        issue_s = cand_valid_s & ~atm_palwr;
    end

    // Palette readback value for group 00 data-port reads
    always_comb begin
`ifdef ULAPLUS_READBACK_EN
        if ((state_q == BUF_PEND) && (pend_addr_q == index_s)) begin
            pal_rd_s = pend_data_q;
        end else begin
            pal_rd_s = shadow_q[index_s];
        end
`else
        pal_rd_s = 8'hFF;
`endif
    end

    // Readback multiplexer for both ports
    always_comb begin
        if (!port_sel) begin
            rd_data_s = reg_sel_q;
        end else begin
            case (group_s)
                2'b00:   rd_data_s = pal_rd_s;
                2'b01:   rd_data_s = {7'd0, up_ena_q};
                default: rd_data_s = 8'hFF;
            endcase
        end
    end

    // Port registers, posting buffer FSM and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= BUF_IDLE;
            reg_sel_q    <= 8'h00;
            up_ena_q     <= 1'b0;
            up_palwr_q   <= 1'b0;
            up_paladdr_q <= 6'd0;
            up_paldata_q <= 8'h00;
            dout_q       <= 8'hFF;
            pend_addr_q  <= 6'd0;
            pend_data_q  <= 8'h00;
        end else begin
            up_palwr_q <= issue_s;
            case (state_q)
                BUF_IDLE, BUF_PEND: begin
                    if (issue_s) begin
                        up_paladdr_q <= cand_addr_s;
                        up_paldata_q <= cand_data_s;
                        state_q      <= BUF_IDLE;
                    end else if (cand_valid_s) begin
                        pend_addr_q <= cand_addr_s;
                        pend_data_q <= cand_data_s;
                        state_q     <= BUF_PEND;
                    end else begin
                        state_q <= BUF_IDLE;
                    end
                end
                default: state_q <= BUF_IDLE;
            endcase
            if (port_wr && !port_sel) begin
                reg_sel_q <= din;
            end
            if (ena_wr_s) begin
                up_ena_q <= din[0];
            end
            if (rd_s) begin
                dout_q <= rd_data_s;
            end
        end
    end

`ifdef ULAPLUS_READBACK_EN
    // Shadow copy of the video palette; written alongside each issued entry, never reset
    always_ff @(posedge clk) begin
        if (issue_s) begin
            shadow_q[cand_addr_s] <= cand_data_s;
        end
    end
`endif

    assign dout       = dout_q;
    assign up_ena     = up_ena_q;
    assign up_palwr   = up_palwr_q;
    assign up_paladdr = up_paladdr_q;
    assign up_paldata = up_paldata_q;

endmodule

// File: tb/tb_ulaplus_ports.sv
// Scoreboard bench for ulaplus_ports: reference model predicts palette pulses, reads and mode enable.
module tb_ulaplus_ports;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       port_wr, port_rd, port_sel, atm_palwr;
    logic [7:0] din;
    logic [7:0] dout;
    logic       up_ena, up_palwr;
    logic [5:0] up_paladdr;
    logic [7:0] up_paldata;

    ulaplus_ports dut (
        .clk(clk), .rst_n(rst_n), .port_wr(port_wr), .port_rd(port_rd),
        .port_sel(port_sel), .din(din), .dout(dout), .atm_palwr(atm_palwr),
        .up_ena(up_ena), .up_palwr(up_palwr), .up_paladdr(up_paladdr),
        .up_paldata(up_paldata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [7:0]  m_reg = 8'h00;
    logic        m_ena = 1'b0;
    logic        m_pend = 1'b0;
    logic [5:0]  m_pa = 6'd0;
    logic [7:0]  m_pd = 8'h00;
    logic [7:0]  m_shadow [64];
    logic        exp_ena = 1'b0;

    logic [13:0] pal_q [$];
    logic [7:0]  rd_q [$];
    logic        rd_seen = 1'b0;
    logic [7:0]  dout_hold = 8'hFF;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] model_read(input logic sel);
        if (!sel) return m_reg;
        case (m_reg[7:6])
`ifdef ULAPLUS_READBACK_EN
            2'b00:   return (m_pend && (m_pa == m_reg[5:0])) ? m_pd : m_shadow[m_reg[5:0]];
`else
            2'b00:   return 8'hFF;
`endif
            2'b01:   return {7'd0, m_ena};
            default: return 8'hFF;
        endcase
    endfunction

    // One clock of stimulus; the model advances by the same edge
    task automatic cycle(input logic wr, input logic rd, input logic sel,
                         input logic [7:0] d, input logic atm);
        port_wr = wr; port_rd = rd; port_sel = sel; din = d; atm_palwr = atm;
        if (wr) begin
            if (!sel) m_reg = d;
            else if (m_reg[7:6] == 2'b00) begin
                m_pend = 1'b1; m_pa = m_reg[5:0]; m_pd = d;
            end else if (m_reg[7:6] == 2'b01) m_ena = d[0];
        end else if (rd) begin
            rd_q.push_back(model_read(sel));
        end
        if (m_pend && !atm) begin
            pal_q.push_back({m_pa, m_pd});
            m_shadow[m_pa] = m_pd;
            m_pend = 1'b0;
        end
        @(posedge clk);
        #1;
        exp_ena = m_ena;
    endtask

    task automatic reg_wr(input logic [7:0] d, input logic atm);
        cycle(1'b1, 1'b0, 1'b0, d, atm);
    endtask
    task automatic dat_wr(input logic [7:0] d, input logic atm);
        cycle(1'b1, 1'b0, 1'b1, d, atm);
    endtask
    task automatic rd(input logic sel);
        cycle(1'b0, 1'b1, sel, 8'h00, 1'b0);
    endtask
    task automatic idle(input logic atm);
        cycle(1'b0, 1'b0, 1'b0, 8'h00, atm);
    endtask

    always @(posedge clk) rd_seen <= port_rd && !port_wr && rst_n;

    // Monitor: compares DUT outputs against the queued expectations away from the active edge
    always @(negedge clk) begin
        logic [13:0] pe;
        logic [7:0]  re;
        if (!rst_n) dout_hold = 8'hFF;
        if (up_palwr) begin
            if (pal_q.size() == 0) begin
                check("palwr_unexpected", {18'd0, up_paladdr, up_paldata}, 32'h0);
            end else begin
                pe = pal_q.pop_front();
                check("palwr_entry", {18'd0, up_paladdr, up_paldata}, {18'd0, pe});
            end
        end
        if (rd_seen) begin
            if (rd_q.size() == 0) begin
                check("dout_unexpected_read", 32'd1, 32'd0);
            end else begin
                re = rd_q.pop_front();
                check("dout_read", {24'd0, dout}, {24'd0, re});
                dout_hold = re;
            end
        end else begin
            check("dout_hold", {24'd0, dout}, {24'd0, dout_hold});
        end
        check("up_ena", {31'd0, up_ena}, {31'd0, exp_ena});
    end

    initial begin
        rst_n = 1'b0; port_wr = 1'b0; port_rd = 1'b0; port_sel = 1'b0;
        din = 8'h00; atm_palwr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_dout", {24'd0, dout}, 32'h0000_00FF);
        check("rst_outs", {17'd0, up_ena, up_palwr, up_paladdr, up_paldata}, 32'h0);
        rst_n = 1'b1;

`ifdef ULAPLUS_READBACK_EN
        for (int i = 0; i < 64; i++) begin
            reg_wr(i[7:0] & 8'h3F, 1'b0);
            dat_wr(8'($urandom), 1'b0);
        end
`endif
        // Basic palette write: one pulse (05,E3)
        reg_wr(8'h05, 1'b0);
        dat_wr(8'hE3, 1'b0);
        idle(1'b0); idle(1'b0);
        // Mode enable and readback
        reg_wr(8'h40, 1'b0);
        dat_wr(8'h01, 1'b0);
        rd(1'b1);
        dat_wr(8'h00, 1'b0);
        rd(1'b1);
        rd(1'b0);
        // Blocked by ATM for five clocks
        idle(1'b1); idle(1'b1);
        reg_wr(8'h3F, 1'b1);
        dat_wr(8'h1C, 1'b1);
        idle(1'b1);
        idle(1'b0); idle(1'b0);
        // Overwrite while pending
        reg_wr(8'h10, 1'b1);
        dat_wr(8'hAA, 1'b1);
        dat_wr(8'h55, 1'b1);
        idle(1'b1);
        idle(1'b0); idle(1'b0);
        // Readback of index 02, then groups 10/11 and simultaneous strobes
        reg_wr(8'h02, 1'b0);
        dat_wr(8'h7A, 1'b0);
        idle(1'b0);
        reg_wr(8'h02, 1'b0);
        rd(1'b1);
        reg_wr(8'h80, 1'b0);
        dat_wr(8'h33, 1'b0);
        rd(1'b1);
        reg_wr(8'hC1, 1'b0);
        rd(1'b1);
        cycle(1'b1, 1'b1, 1'b0, 8'h47, 1'b0);
        rd(1'b0);
        // Reset while an entry is pending
        reg_wr(8'h20, 1'b1);
        dat_wr(8'h99, 1'b1);
        #2;
        rst_n = 1'b0;
        m_reg = 8'h00; m_ena = 1'b0; m_pend = 1'b0; exp_ena = 1'b0;
        #1;
        check("async_rst_dout", {24'd0, dout}, 32'h0000_00FF);
        check("async_rst_outs", {17'd0, up_ena, up_palwr, up_paladdr, up_paldata}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1'b0); idle(1'b0); idle(1'b0);
        rd(1'b0);

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            int unsigned r;
            logic [7:0] d;
            logic atm;
            r = $urandom_range(0, 9);
            d = 8'($urandom);
            atm = ($urandom_range(0, 2) == 0);
            if (r <= 2) begin
                d[7] = ($urandom_range(0, 3) == 0);
                reg_wr(d, atm);
            end else if (r <= 5) dat_wr(d, atm);
            else if (r <= 7) cycle(1'b0, 1'b1, 1'($urandom_range(0, 1)), 8'h00, atm);
            else if (r == 8) cycle(1'b1, 1'b1, 1'($urandom_range(0, 1)), d, atm);
            else idle(atm);
        end
        idle(1'b0); idle(1'b0); idle(1'b0);
        check("pal_queue_drained", pal_q.size(), 32'd0);
        check("rd_queue_drained", rd_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
